// File: rtl/alu_pkg.sv
// Shared definitions for the ALU with iterative multiply/divide:
// function codes, engine FSM states and engine operation select.
package alu_pkg;

   localparam logic [5:0] CTRL_SLL   = 6'd0;
   localparam logic [5:0] CTRL_SRL   = 6'd2;
   localparam logic [5:0] CTRL_MFHI  = 6'd16;
   localparam logic [5:0] CTRL_MFLO  = 6'd18;
   localparam logic [5:0] CTRL_MULTU = 6'd25;
   localparam logic [5:0] CTRL_DIVU  = 6'd27;
   localparam logic [5:0] CTRL_ADD   = 6'd32;
   localparam logic [5:0] CTRL_SUB   = 6'd34;
   localparam logic [5:0] CTRL_AND   = 6'd36;
   localparam logic [5:0] CTRL_OR    = 6'd37;
   localparam logic [5:0] CTRL_SLT   = 6'd42;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } md_op_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle of the ALU: operation request in, registered
// result and engine status out.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [5:0]       ctrl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output in_valid, ctrl, A, B,
      input  result, result_valid, busy, done, err
   );

   modport slave (
      input  in_valid, ctrl, A, B,
      output result, result_valid, busy, done, err
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per RUN cycle; HI/LO are only written when the last
// iteration completes, so an aborted run never leaves partial results.
module muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  md_op_t           i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int              CNT_W = $clog2(CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   state_t           r_state;
   md_op_t           r_op;
   logic [WIDTH-1:0] r_acc;    // product high half / partial remainder
   logic [WIDTH-1:0] r_q;      // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] r_opnd;   // multiplicand / divisor
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_acc_nx;
   logic [WIDTH-1:0] w_q_nx;

   // One iteration of the selected algorithm from the current partial state.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      w_acc_nx = r_acc;
      w_q_nx   = r_q;
      w_sum    = {1'b0, r_acc} + {1'b0, {WIDTH{r_q[0]}} & r_opnd};
      w_shift  = {r_acc, r_q[WIDTH-1]};
      w_ge     = (w_shift >= {1'b0, r_opnd});
      // When w_ge holds the true difference is below the divisor, so the
      // low WIDTH bits of the subtraction are exact.
      w_diff   = w_shift[WIDTH-1:0] - r_opnd;
      if (r_op == OP_MUL) begin
         w_acc_nx = w_sum[WIDTH:1];
         w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
      end else begin
         w_acc_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
         w_q_nx   = {r_q[WIDTH-2:0], w_ge};
      end
   end

   // Engine FSM: latch operands, iterate, publish HI/LO with a done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_MUL;
         r_acc   <= '0;
         r_q     <= '0;
         r_opnd  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_state <= ST_IDLE;
               if (i_start) begin
                  if (i_op == OP_DIV && i_b == '0) begin
                     // Divide by zero: skip the engine, publish fixed values.
                     r_hi    <= i_a;
                     r_lo    <= '1;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_op    <= i_op;
                     r_acc   <= '0;
                     r_q     <= (i_op == OP_MUL) ? i_b : i_a;
                     r_opnd  <= (i_op == OP_MUL) ? i_a : i_b;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_acc <= w_acc_nx;
               r_q   <= w_q_nx;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_hi    <= w_acc_nx;
                  r_lo    <= w_q_nx;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// ALU top: function-code decode, single-cycle datapath, registered
// result/err outputs and the iterative multiply/divide engine.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input logic         clk,
   input logic         rst,
   alu_muldiv_if.slave bus
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH-1:0] r_result;
   logic             r_result_valid;
   logic             r_err;

   logic             w_busy;
   logic             w_done;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic             w_accept;
   logic             w_simple;
   logic             w_md;
   logic             w_illegal;
   logic             w_div;
   logic             w_div_zero;
   logic             w_start;
   logic [SH_W-1:0]  w_shamt;
   logic [WIDTH-1:0] w_simple_res;

   // Requests arriving while the engine runs are dropped without side effects.
   assign w_accept   = bus.in_valid & ~w_busy;
   assign w_shamt    = bus.B[SH_W-1:0];
   assign w_div      = (bus.ctrl == CTRL_DIVU);
   assign w_div_zero = w_div & (bus.B == '0);
   assign w_illegal  = ~w_simple & ~w_md;
   assign w_start    = w_accept & w_md;

   // Decode the function code and compute the single-cycle result.
   always_comb begin
      w_simple     = 1'b1;
      w_md         = 1'b0;
      w_simple_res = '0;
      case (bus.ctrl)
         CTRL_AND:  w_simple_res = bus.A & bus.B;
         CTRL_OR:   w_simple_res = bus.A | bus.B;
         CTRL_ADD:  w_simple_res = bus.A + bus.B;
         CTRL_SUB:  w_simple_res = bus.A - bus.B;
         CTRL_SLT:  w_simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         CTRL_SLL:  w_simple_res = bus.A << w_shamt;
         CTRL_SRL:  w_simple_res = bus.A >> w_shamt;
         CTRL_MFHI: w_simple_res = w_hi;
         CTRL_MFLO: w_simple_res = w_lo;
         CTRL_MULTU, CTRL_DIVU: begin
            w_simple = 1'b0;
            w_md     = 1'b1;
         end
         default:   w_simple = 1'b0;
      endcase
   end

   // Register simple-op results; err pulses on illegal codes and divide by zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_result_valid <= w_accept & w_simple;
         r_err          <= w_accept & (w_illegal | w_div_zero);
         if (w_accept & w_simple) begin
            r_result <= w_simple_res;
         end
      end
   end

   muldiv_seq #(
      .WIDTH  (WIDTH),
      .CYCLES (MUL_CYCLES)
   ) u_muldiv (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_op    (w_div ? OP_DIV : OP_MUL),
      .i_a     (bus.A),
      .i_b     (bus.B),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_hi    (w_hi),
      .o_lo    (w_lo)
   );

   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.err          = r_err;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 Parameter: MUL_CYCLES, default WIDTH, iteration count of the sequential multiply/divide engine (fixed equal to WIDTH in this generation).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request; sampled each rising edge.
REQ-006 ctrl  input  6  function code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18).
REQ-007 A  input  WIDTH  operand A (SLL/SRL: value to shift).
REQ-008 B  input  WIDTH  operand B (SLL/SRL: shift amount, low log2(WIDTH) bits only).
REQ-009 result  output  WIDTH  registered result.
REQ-010 result_valid  output  1  one-cycle pulse: result updated this cycle.
REQ-011 busy  output  1  high while the multiply/divide engine is running.
REQ-012 done  output  1  one-cycle pulse when HI/LO are written.
REQ-013 err  output  1  one-cycle pulse on illegal ctrl or DIVU with B=0.

Function
REQ-014 Simple ops (AND, OR, ADD, SUB, SLT, SLL, SRL, MFHI, MFLO): when in_valid=1 and busy=0, result and result_valid=1 are registered at the next edge (latency 1).
REQ-015 ADD/SUB wrap modulo 2^WIDTH; no overflow flag; SLT is signed compare, result 1 or 0 zero-extended.
REQ-016 SRL is logical (zero fill); shift amount >= WIDTH cannot occur (masked per REQ-008).
REQ-017 MFHI/MFLO return the current HI/LO register contents.
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid with MULTU or DIVU while busy=0; operands latched at that edge.
REQ-019 RUN lasts exactly MUL_CYCLES cycles (shift-add for MULTU, restoring for DIVU), busy=1 throughout; then DONE.
REQ-020 DONE lasts one cycle: HI/LO written, done=1, busy=0; DONE->IDLE unconditionally.
REQ-021 MULTU: {HI,LO} = A*B unsigned, 2*WIDTH bits.
REQ-022 DIVU: LO = A/B, HI = A%B unsigned.
REQ-023 DIVU with B=0: no engine start; err=1 next cycle, HI=A, LO=all ones, done=1 in that same cycle.
REQ-024 in_valid while busy=1: ignored entirely; result, HI, LO unchanged; err not raised.
REQ-025 in_valid in DONE cycle: accepted normally; MFHI/MFLO there return the newly written values.
REQ-026 Illegal ctrl with in_valid and busy=0: err=1, result unchanged, result_valid=0.
REQ-027 MULTU/DIVU acceptance does not pulse result_valid; result holds its previous value.
REQ-028 Total MULTU/DIVU latency: request edge to done pulse = MUL_CYCLES+1 cycles.

Reset
REQ-029 rst=0 asynchronously forces result=0, HI=0, LO=0, result_valid=0, busy=0, done=0, err=0, FSM=IDLE.
REQ-030 Reset during RUN aborts the operation; no partial HI/LO write; first accepted request after release behaves as from power-up.

Structure
REQ-031 Shared package alu_pkg holds the ctrl code constants and FSM state enumeration.
REQ-032 Sub-module muldiv_seq implements the iterative engine (start, op select, operands in; busy, done, HI, LO out); alu_muldiv holds the simple-op datapath, ctrl decode and output registers.

Verification
REQ-033 Reset, then ADD A=7 B=5 -> next cycle result=12, result_valid=1; SUB A=5 B=7 -> result=0xFFFFFFFE.
REQ-034 SLT A=0xFFFFFFFF B=1 -> result=1; SRL A=0x80000000 B=31 -> result=1; SLL A=1 B=35 -> result=8.
REQ-035 MULTU A=50 B=2 -> busy 32 cycles, done on cycle 33; MFHI -> 0, MFLO -> 100; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1.
REQ-036 DIVU A=100 B=7 -> LO=14, HI=2; DIVU A=9 B=0 -> err=1, done=1, HI=9, LO=0xFFFFFFFF, no busy.
REQ-037 ADD issued while busy -> ignored, result unchanged; rst=0 mid-RUN -> busy=0 immediately, MFLO after release -> 0.
REQ-038 Repeat REQ-033 and REQ-035 with WIDTH=16: MULTU 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=1, done after 17 cycles.
